// File: rtl/nf_rule_merge_avlstrm.sv
// Rule-ID merge stage: tallies non-zero rule IDs per packet, drops rule-less packets,
// forwards {rule_cnt, meta} then the packet. Rule lane i is data[i*RULE_W +: RULE_W].
`timescale 1ns/1ps
module nf_rule_merge_avlstrm #(
    parameter int DATA_W = 512,
    parameter int META_W = 128,
    parameter int RULE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [META_W-1:0]         in_meta_data,
    input  logic                      in_meta_valid,
    output logic                      in_meta_ready,
    input  logic [DATA_W-1:0]         in_rule_data,
    input  logic                      in_rule_valid,
    input  logic                      in_rule_sop,
    input  logic                      in_rule_eop,
    input  logic [5:0]                in_rule_empty,
    output logic                      in_rule_ready,
    input  logic [DATA_W-1:0]         in_pkt_data,
    input  logic                      in_pkt_valid,
    input  logic                      in_pkt_sop,
    input  logic                      in_pkt_eop,
    input  logic [5:0]                in_pkt_empty,
    output logic                      in_pkt_ready,
    output logic [META_W+CNT_W-1:0]   out_meta_data,
    output logic                      out_meta_valid,
    input  logic                      out_meta_ready,
    output logic [DATA_W-1:0]         out_pkt_data,
    output logic                      out_pkt_valid,
    output logic                      out_pkt_sop,
    output logic                      out_pkt_eop,
    output logic [5:0]                out_pkt_empty,
    input  logic                      out_pkt_ready,
    output logic [31:0]               stats_fwd_pkt,
    output logic [31:0]               stats_drop_pkt,
    output logic [31:0]               stats_rule
);

    localparam int LANES = DATA_W / RULE_W;

    typedef enum logic [2:0] {IDLE, RULE, META, FWD, DROP} state_t;

    state_t              state;
    logic                meta_rdy, rule_rdy, meta_vld, fwd_q, drop_q;
    logic [META_W-1:0]   meta_q;
    logic [CNT_W-1:0]    rule_cnt;
    logic [6:0]          lane_lim;
    logic [5:0]          pop;
    logic [CNT_W-1:0]    cnt_base, cnt_nxt;
    logic [CNT_W:0]      sum;
    logic                meta_acc, rule_acc, pkt_end;

    // A sop beat restarts the tally; a missing first sop is harmless since
    // rule_cnt is already cleared when the metadata beat is taken.
    always_comb begin
        lane_lim = (7'd64 - {1'b0, in_rule_empty}) >> 1;
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_rule_data[i*RULE_W +: RULE_W] != '0 &&
                (!in_rule_eop || 7'(i) < lane_lim))
                pop = pop + 6'd1;
        end
        cnt_base = in_rule_sop ? '0 : rule_cnt;
        sum = {1'b0, cnt_base} + {{(CNT_W-5){1'b0}}, pop};
        cnt_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    assign meta_acc = in_meta_valid & meta_rdy;
    assign rule_acc = in_rule_valid & rule_rdy;
    assign pkt_end  = in_pkt_valid & in_pkt_ready & in_pkt_eop;

    assign in_meta_ready  = meta_rdy;
    assign in_rule_ready  = rule_rdy;
    assign out_meta_valid = meta_vld;
    assign out_meta_data  = {rule_cnt, meta_q};
    assign in_pkt_ready   = drop_q | (fwd_q & out_pkt_ready);
    assign out_pkt_valid  = fwd_q & in_pkt_valid;
    assign out_pkt_sop    = fwd_q & in_pkt_sop;
    assign out_pkt_eop    = fwd_q & in_pkt_eop;
    assign out_pkt_data   = in_pkt_data;
    assign out_pkt_empty  = in_pkt_empty;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            meta_rdy       <= 1'b0;
            rule_rdy       <= 1'b0;
            meta_vld       <= 1'b0;
            fwd_q          <= 1'b0;
            drop_q         <= 1'b0;
            meta_q         <= '0;
            rule_cnt       <= '0;
            stats_fwd_pkt  <= '0;
            stats_drop_pkt <= '0;
            stats_rule     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    meta_rdy <= 1'b1;
                    if (meta_acc) begin
                        meta_q   <= in_meta_data;
                        rule_cnt <= '0;
                        meta_rdy <= 1'b0;
                        rule_rdy <= 1'b1;
                        state    <= RULE;
                    end
                end
                RULE: begin
                    if (rule_acc) begin
                        rule_cnt <= cnt_nxt;
                        if (in_rule_eop) begin
                            rule_rdy <= 1'b0;
                            if (cnt_nxt == '0) begin
                                drop_q <= 1'b1;
                                state  <= DROP;
                            end else begin
                                meta_vld <= 1'b1;
                                state    <= META;
                            end
                        end
                    end
                end
                META: begin
                    if (out_meta_ready) begin
                        meta_vld <= 1'b0;
                        fwd_q    <= 1'b1;
                        state    <= FWD;
                    end
                end
                FWD: begin
                    if (pkt_end) begin
                        stats_fwd_pkt <= stats_fwd_pkt + 32'd1;
                        stats_rule    <= stats_rule + {{(32-CNT_W){1'b0}}, rule_cnt};
                        fwd_q         <= 1'b0;
                        meta_rdy      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                DROP: begin
                    if (pkt_end) begin
                        stats_drop_pkt <= stats_drop_pkt + 32'd1;
                        drop_q         <= 1'b0;
                        meta_rdy       <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
